tree_multiplier_csa_pipelined: RTL and testbench

TREE_MULTIPLIER_CSA_PIPELINED -- requirements
Module: tree_multiplier_csa_pipelined

---
 rtl/tree_multiplier_csa_pipelined_pkg.sv | 44 ++++
 rtl/csa_mult_core.sv | 74 +++++++
 rtl/tree_multiplier_csa_pipelined.sv | 116 +++++++++++
 tb/tb_tree_multiplier_csa_pipelined.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_multiplier_csa_pipelined_pkg.sv
// mult_pkg: shared defaults and elaboration-time helpers for the CSA tree multiplier.
//   DEF_WIDTH / DEF_STAGES / DEF_DIV : default operand width, pipeline depth, issue interval
//   result_width()                   : product width for a given operand width
//   csa_next_rows / csa_rows_at / csa_levels : row counts through the 3:2 reduction tree
package mult_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_STAGES = 2;
    localparam int unsigned DEF_DIV    = 4;

    // Exact product width for two WIDTH-bit operands.
    function automatic int unsigned result_width(input int unsigned width);
        return 2 * width;
    endfunction

    // Rows left after one layer of 3:2 compressors over n rows.
    function automatic int unsigned csa_next_rows(input int unsigned n);
        return (n / 3) * 2 + (n % 3);
    endfunction

    // Rows present at tree level lvl, starting from n0 partial products.
    function automatic int unsigned csa_rows_at(input int unsigned n0, input int unsigned lvl);
        int unsigned n;
        n = n0;
        for (int unsigned i = 0; i < lvl; i++) begin
            n = csa_next_rows(n);
        end
        return n;
    endfunction

    // Number of compressor layers needed to reach two rows.
    function automatic int unsigned csa_levels(input int unsigned n0);
        int unsigned n;
        int unsigned k;
        n = n0;
        k = 0;
        while (n > 2) begin
            n = csa_next_rows(n);
            k = k + 1;
        end
        return k;
    endfunction

endpackage

// File: rtl/csa_mult_core.sv
// csa_mult_core: combinational signed/unsigned multiplier built from a
// carry-save (3:2 compressor) reduction tree and a final carry-propagate add.
//   a         : multiplicand, WIDTH bits
//   b         : multiplier, WIDTH bits
//   is_signed : 1 = two's-complement operands, 0 = unsigned
//   product   : exact 2*WIDTH-bit product
module csa_mult_core
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]               a,
    input  logic [WIDTH-1:0]               b,
    input  logic                           is_signed,
    output logic [result_width(WIDTH)-1:0] product
);

    localparam int unsigned PW   = result_width(WIDTH);
    localparam int unsigned NPP  = WIDTH + 1;
    localparam int unsigned NLVL = csa_levels(NPP);

    logic [PW-1:0] a_ext;
    logic          neg_row;

    // tree[l][r]: row r at reduction level l; rows past the live count are tied to zero.
    logic [PW-1:0] tree [NLVL+1][NPP];

    // Extend the multiplicand to full product width so every row is exact mod 2^PW.
    assign a_ext   = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    // In signed mode the multiplier MSB carries weight -2^(WIDTH-1): that row is negated.
    assign neg_row = is_signed & b[WIDTH-1];

    // Partial products for the non-negative multiplier bits.
    for (genvar r = 0; r < WIDTH - 1; r++) begin : g_pp
        assign tree[0][r] = b[r] ? (a_ext << r) : '0;
    end

    // MSB row: negation is done as one's complement here plus a +1 correction row.
    assign tree[0][WIDTH-1] = !b[WIDTH-1] ? '0 :
                              neg_row     ? ~(a_ext << (WIDTH - 1)) :
                                            (a_ext << (WIDTH - 1));
    assign tree[0][WIDTH]   = PW'(neg_row);

    // Each level compresses groups of three rows into sum + shifted carry.
    for (genvar l = 1; l <= NLVL; l++) begin : g_lvl
        localparam int unsigned NP = csa_rows_at(NPP, l - 1);
        localparam int unsigned NG = NP / 3;
        localparam int unsigned NO = csa_rows_at(NPP, l);

        for (genvar g = 0; g < NG; g++) begin : g_csa
            logic [PW-1:0] x;
            logic [PW-1:0] y;
            logic [PW-1:0] z;
            assign x = tree[l-1][3*g];
            assign y = tree[l-1][3*g+1];
            assign z = tree[l-1][3*g+2];
            assign tree[l][2*g]   = x ^ y ^ z;
            // Carry out of the top bit is beyond 2^PW and safely dropped.
            assign tree[l][2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
        end

        for (genvar r = 0; r < NP - 3 * NG; r++) begin : g_pass
            assign tree[l][2*NG+r] = tree[l-1][3*NG+r];
        end

        for (genvar r = NO; r < NPP; r++) begin : g_zero
            assign tree[l][r] = '0;
        end
    end

    // Final carry-propagate addition of the two surviving rows.
    assign product = tree[NLVL][0] + tree[NLVL][1];

endmodule

// File: rtl/tree_multiplier_csa_pipelined.sv
// tree_multiplier_csa_pipelined: rate-controlled, pipelined CSA-tree multiplier
// with valid/ready handshakes. A tick enable (one per DIV clocks) shifts a chain
// of STAGES result slots; the last slot drives the output.
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : operand pair present
//   in_ready   : operand pair accepted this cycle when in_valid is high
//   in_a, in_b : WIDTH-bit operands
//   in_signed  : 1 = two's-complement, 0 = unsigned (sampled with the operands)
//   out_valid  : out_result holds a product
//   out_ready  : consumer takes the product
//   out_result : 2*WIDTH-bit product
module tree_multiplier_csa_pipelined
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES,
    parameter int unsigned DIV    = DEF_DIV
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_a,
    input  logic [WIDTH-1:0]               in_b,
    input  logic                           in_signed,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [result_width(WIDTH)-1:0] out_result
);

    localparam int unsigned RW = result_width(WIDTH);

    logic          tick_c;
    logic          stall_c;
    logic          advance_c;
    logic [RW-1:0] core_prod;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [RW-1:0]     prod_q [STAGES];
    logic [RW-1:0]     prod_d [STAGES];

    // Combinational product feeding the first slot.
    csa_mult_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a        (in_a),
        .b        (in_b),
        .is_signed(in_signed),
        .product  (core_prod)
    );

    // Issue-rate enable: free-running counter, never gated by stalls.
    if (DIV == 1) begin : g_no_div
        assign tick_c = 1'b1;
    end else begin : g_div
        localparam int unsigned CW = $clog2(DIV);

        logic [CW-1:0] div_cnt_q;
        logic [CW-1:0] div_cnt_d;

        always_comb begin
            div_cnt_d = div_cnt_q + CW'(1);
            if (div_cnt_q == CW'(DIV - 1)) begin
                div_cnt_d = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                div_cnt_q <= '0;
            end else begin
                div_cnt_q <= div_cnt_d;
            end
        end

        assign tick_c = (div_cnt_q == CW'(DIV - 1));
    end

    // A held, untaken product blocks the whole chain.
    assign stall_c   = vld_q[STAGES-1] & ~out_ready;
    assign advance_c = tick_c & ~stall_c;
    assign in_ready  = advance_c;

    // Slot chain next state: shift on advance, otherwise only retire a taken output.
    always_comb begin
        vld_d  = vld_q;
        prod_d = prod_q;
        if (advance_c) begin
            vld_d[0]  = in_valid;
            prod_d[0] = core_prod;
            for (int unsigned k = 1; k < STAGES; k++) begin
                vld_d[k]  = vld_q[k-1];
                prod_d[k] = prod_q[k-1];
            end
        end else if (vld_q[STAGES-1] && out_ready) begin
            vld_d[STAGES-1] = 1'b0;
        end
    end

    // Slot chain registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            prod_q <= '{default: '0};
        end else begin
            vld_q  <= vld_d;
            prod_q <= prod_d;
        end
    end

    assign out_valid  = vld_q[STAGES-1];
    assign out_result = prod_q[STAGES-1];

endmodule

// File: tb/tb_tree_multiplier_csa_pipelined.sv
// Directed and randomized checks of tree_multiplier_csa_pipelined across three
// parameter sets: (W32,S2,D4), (W32,S3,D1), (W8,S1,D2).
module tb_tree_multiplier_csa_pipelined;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        v0, rdy0, s0, ir0, ov0;
    logic [31:0] a0, b0;
    logic [63:0] res0;

    logic        v1, rdy1, s1, ir1, ov1;
    logic [31:0] a1, b1;
    logic [63:0] res1;

    logic        v2, rdy2, s2, ir2, ov2;
    logic [7:0]  a2, b2;
    logic [15:0] res2;

    int n_cmp = 0;
    int n_err = 0;

    tree_multiplier_csa_pipelined #(.WIDTH(32), .STAGES(2), .DIV(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(ir0), .in_a(a0), .in_b(b0),
        .in_signed(s0), .out_valid(ov0), .out_ready(rdy0), .out_result(res0));

    tree_multiplier_csa_pipelined #(.WIDTH(32), .STAGES(3), .DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_a(a1), .in_b(b1),
        .in_signed(s1), .out_valid(ov1), .out_ready(rdy1), .out_result(res1));

    tree_multiplier_csa_pipelined #(.WIDTH(8), .STAGES(1), .DIV(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .in_a(a2), .in_b(b2),
        .in_signed(s2), .out_valid(ov2), .out_ready(rdy2), .out_result(res2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus for DUT d; the other DUTs idle and drain.
    task automatic cyc(input int d, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic r,
                       output logic ir, output logic ov, output logic [63:0] res);
        v0 = 1'b0; rdy0 = 1'b1;
        v1 = 1'b0; rdy1 = 1'b1;
        v2 = 1'b0; rdy2 = 1'b1;
        case (d)
            0:       begin v0 = v; a0 = a; b0 = b; s0 = s; rdy0 = r; end
            1:       begin v1 = v; a1 = a; b1 = b; s1 = s; rdy1 = r; end
            default: begin v2 = v; a2 = a[7:0]; b2 = b[7:0]; s2 = s; rdy2 = r; end
        endcase
        #1;
        case (d)
            0:       begin ir = ir0; ov = ov0; res = res0; end
            1:       begin ir = ir1; ov = ov1; res = res1; end
            default: begin ir = ir2; ov = ov2; res = {48'b0, res2}; end
        endcase
        @(posedge clk);
        #1;
    endtask

    // Hold an operand pair until accepted; waited = cycles with in_ready low first.
    task automatic wait_accept(input int d, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic r, output int waited);
        logic ir, ov;
        logic [63:0] res;
        waited = 999;
        for (int i = 0; i < 64; i++) begin
            cyc(d, 1'b1, a, b, s, r, ir, ov, res);
            if (ir) begin
                waited = i;
                break;
            end
        end
    endtask

    // Wait with out_ready high for the next product; lat counts cycles after acceptance.
    task automatic wait_out(input int d, output int lat, output logic [63:0] res);
        logic ir, ov;
        lat = 999;
        res = '1;
        for (int i = 1; i <= 60; i++) begin
            cyc(d, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, ir, ov, res);
            if (ov) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [63:0] exp);
        int waited, lat;
        logic [63:0] res;
        wait_accept(0, a, b, s, 1'b1, waited);
        wait_out(0, lat, res);
        chk(tag, res, exp);
    endtask

    function automatic logic [63:0] model(input int w, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] p;
        if (w == 8) begin
            if (s) begin
                sa = $signed({{56{a[7]}}, a[7:0]});
                sb = $signed({{56{b[7]}}, b[7:0]});
                p  = sa * sb;
            end else begin
                p = {56'b0, a[7:0]} * {56'b0, b[7:0]};
            end
            return {48'b0, p[15:0]};
        end
        if (s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            p  = sa * sb;
        end else begin
            p = {32'b0, a} * {32'b0, b};
        end
        return p;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] x;
        case ($urandom_range(5, 0))
            0:       x = 32'd0;
            1:       x = 32'hFFFF_FFFF;
            2:       x = 32'd1 << (w - 1);
            3:       x = (32'd1 << (w - 1)) - 32'd1;
            default: x = $urandom;
        endcase
        if (w == 8) x = x & 32'hFF;
        return x;
    endfunction

    initial begin
        logic ir, ov, r, v, s, prev_stall;
        logic [63:0] res, hold, exp;
        logic [31:0] a, b;
        int waited, lat, nxt, got, stalled, bad_ready, unstable, stale, first_ir;
        int w, done, cycles;
        logic [63:0] sb_q[$];

        rst = 1'b1;
        v0 = 0; rdy0 = 1; s0 = 0; a0 = 0; b0 = 0;
        v1 = 0; rdy1 = 1; s1 = 0; a1 = 0; b1 = 0;
        v2 = 0; rdy2 = 1; s2 = 0; a2 = 0; b2 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov0", 64'(ov0), 64'd0);
        chk("rst_res0", res0, 64'd0);
        chk("rst_ov1", 64'(ov1), 64'd0);
        chk("rst_res1", res1, 64'd0);
        chk("rst_ov2", 64'(ov2), 64'd0);
        chk("rst_res2", 64'(res2), 64'd0);
        rst = 1'b0;

        // 3 x 5 unsigned on W32/S2/D4: first tick 3 cycles after release, latency 5.
        wait_accept(0, 32'd3, 32'd5, 1'b0, 1'b1, waited);
        chk("first_ready", 64'(waited), 64'd3);
        wait_out(0, lat, res);
        chk("lat31", 64'(lat), 64'd5);
        chk("prod31", res, 64'd15);
        cyc(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, ir, ov, res);
        chk("drop31", 64'(ov), 64'd0);

        // Corner operands.
        run_one("s_m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
        run_one("u_m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        run_one("s_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        run_one("s_m3_5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
        run_one("u_min_2", 32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000);
        run_one("s_max_min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000);

        // Two products in flight, output stalled, then reset pulse.
        wait_accept(0, 32'd11, 32'd13, 1'b0, 1'b0, waited);
        wait_accept(0, 32'd17, 32'd19, 1'b0, 1'b0, waited);
        cyc(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, ir, ov, res);
        chk("hold35_ov", 64'(ov), 64'd1);
        chk("hold35_res", res, 64'd143);
        rst = 1'b1;
        cyc(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, ir, ov, res);
        rst = 1'b0;
        stale = 0;
        first_ir = -1;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, ir, ov, res);
            if (i == 0) begin
                chk("rst35_ov", 64'(ov), 64'd0);
                chk("rst35_res", res, 64'd0);
            end
            if (ov) stale++;
            if (ir && first_ir < 0) first_ir = i;
        end
        chk("rst35_ready", 64'(first_ir), 64'd3);
        chk("rst35_stale", 64'(stale), 64'd0);

        // Stream 1..10 x 7 on W32/S3/D1 with out_ready low in cycles 5-8.
        nxt = 1; got = 0; stalled = 0; bad_ready = 0; unstable = 0; prev_stall = 0; hold = '0;
        for (int cy = 0; cy < 60; cy++) begin
            r = !(cy >= 5 && cy <= 8);
            v = (nxt <= 10);
            cyc(1, v, 32'(nxt), 32'd7, 1'b0, r, ir, ov, res);
            if (ov && !r) begin
                stalled++;
                if (ir) bad_ready++;
                if (prev_stall && res !== hold) unstable++;
                hold = res;
            end
            prev_stall = ov && !r;
            if (v && ir) nxt++;
            if (ov && r) begin
                got++;
                chk("ord33", res, 64'(7 * got));
            end
        end
        chk("cnt33", 64'(got), 64'd10);
        chk("stall33", 64'(stalled), 64'd4);
        chk("ready33", 64'(bad_ready), 64'd0);
        chk("stable33", 64'(unstable), 64'd0);

        // Stream 1..8 x 3 signed with out_ready toggling every cycle.
        nxt = 1; got = 0; unstable = 0; prev_stall = 0; hold = '0;
        for (int cy = 0; cy < 80; cy++) begin
            r = (cy % 2) == 1;
            v = (nxt <= 8);
            cyc(1, v, 32'(nxt), 32'd3, 1'b1, r, ir, ov, res);
            if (prev_stall && (!ov || res !== hold)) unstable++;
            prev_stall = ov && !r;
            hold = res;
            if (v && ir) nxt++;
            if (ov && r) begin
                got++;
                chk("ord34", res, 64'(3 * got));
            end
        end
        chk("cnt34", 64'(got), 64'd8);
        chk("hold34", 64'(unstable), 64'd0);

        // Random operands and handshakes against the reference model.
        for (int d = 1; d <= 2; d++) begin
            w = (d == 2) ? 8 : 32;
            sb_q.delete();
            done = 0; cycles = 0; bad_ready = 0;
            while (done < 5000 && cycles < 30000) begin
                v = ($urandom_range(3, 0) != 0);
                r = ($urandom_range(3, 0) != 0);
                s = 1'($urandom_range(1, 0));
                a = pick(w);
                b = pick(w);
                cyc(d, v, a, b, s, r, ir, ov, res);
                if (v && ir) sb_q.push_back(model(w, s, a, b));
                if (ov && !r && ir) bad_ready++;
                if (ov && r) begin
                    if (sb_q.size() == 0) begin
                        chk("rnd_extra", 64'd1, 64'd0);
                    end else begin
                        exp = sb_q.pop_front();
                        chk("rnd_prod", res, exp);
                    end
                    done++;
                end
                cycles++;
            end
            chk("rnd_done", 64'(done), 64'd5000);
            chk("rnd_ready", 64'(bad_ready), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
